// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider: each channel emits a divided waveform,
// a start-of-period tick and a busy flag, reloading its settings only at period ends.
module clock_div_prog #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [CHANNELS-1:0]       en_i,
    input  logic [CHANNELS*WIDTH-1:0] period_i,
    input  logic [CHANNELS*WIDTH-1:0] high_i,
    output logic [CHANNELS-1:0]       clk_o,
    output logic [CHANNELS-1:0]       tick_o,
    output logic [CHANNELS-1:0]       busy_o
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        logic             state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] per_q, per_d;
        logic [WIDTH-1:0] high_q, high_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             busy_q, busy_d;
        logic [WIDTH-1:0] period_in;
        logic [WIDTH-1:0] high_in;
        logic             start_ok;

        assign period_in = period_i[n*WIDTH +: WIDTH];
        assign high_in   = high_i[n*WIDTH +: WIDTH];
        assign start_ok  = en_i[n] && (period_in >= WIDTH'(2));

        // Settings are only sampled when a new period begins, so outputs never glitch.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            per_d   = per_q;
            high_d  = high_q;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        per_d   = period_in;
                        high_d  = high_in;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == per_q - WIDTH'(1)) begin
                        cnt_d = '0;
                        if (start_ok) begin
                            per_d  = period_in;
                            high_d = high_in;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            // Outputs are computed from next state so they can be registered without lag.
            busy_d = (state_d == ST_RUN);
            tick_d = (state_d == ST_RUN) && (cnt_d == '0);
            clk_d  = (state_d == ST_RUN) && (cnt_d < high_d);
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                per_q   <= '0;
                high_q  <= '0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                per_q   <= per_d;
                high_q  <= high_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
                busy_q  <= busy_d;
            end
        end

        assign clk_o[n]  = clk_q;
        assign tick_o[n] = tick_q;
        assign busy_o[n] = busy_q;
    end

endmodule

// File: tb/tb_clock_div_prog.sv
// Randomized and directed bench for clock_div_prog, checked against a
// period-waveform queue model per channel.
module tb_clock_div_prog;

    logic        clk_i;
    logic        reset_i;
    logic [1:0]  en_i;
    logic [31:0] period_i;
    logic [31:0] high_i;
    logic [1:0]  clk_o;
    logic [1:0]  tick_o;
    logic [1:0]  busy_o;

    int total;
    int bad;

    // Each queue holds the {tick, clk} values still owed for the current period.
    logic [1:0] exp0[$];
    logic [1:0] exp1[$];

    clock_div_prog #(.CHANNELS(2), .WIDTH(16)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .en_i     (en_i),
        .period_i (period_i),
        .high_i   (high_i),
        .clk_o    (clk_o),
        .tick_o   (tick_o),
        .busy_o   (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b (busy,tick,clk x ch1ch0) at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [5:0] modelOutputs();
        logic [1:0] e0;
        logic [1:0] e1;
        logic       b0;
        logic       b1;
        b0 = (exp0.size() > 0);
        b1 = (exp1.size() > 0);
        e0 = b0 ? exp0[0] : 2'b00;
        e1 = b1 ? exp1[0] : 2'b00;
        return {b1, b0, e1[1], e0[1], e1[0], e0[0]};
    endfunction

    // A finished cycle is consumed; an empty queue means the channel may start a new period.
    task automatic modelStep();
        for (int ch = 0; ch < 2; ch++) begin
            int p;
            int h;
            p = int'(period_i[ch*16 +: 16]);
            h = int'(high_i[ch*16 +: 16]);
            if (ch == 0) begin
                if (exp0.size() > 0) void'(exp0.pop_front());
                if (exp0.size() == 0 && en_i[0] && p >= 2)
                    for (int i = 0; i < p; i++) exp0.push_back({i == 0, i < h});
            end else begin
                if (exp1.size() > 0) void'(exp1.pop_front());
                if (exp1.size() == 0 && en_i[1] && p >= 2)
                    for (int i = 0; i < p; i++) exp1.push_back({i == 0, i < h});
            end
        end
    endtask

    // Called just after a rising edge: drive inputs, check at the falling edge, advance the model.
    task automatic applyStimulus(input string tag, input logic [1:0] en,
                                 input logic [15:0] p0, input logic [15:0] h0,
                                 input logic [15:0] p1, input logic [15:0] h1);
        en_i     = en;
        period_i = {p1, p0};
        high_i   = {h1, h0};
        @(negedge clk_i);
        checkOutput(tag, {busy_o, tick_o, clk_o}, modelOutputs());
        @(posedge clk_i);
        modelStep();
        #1;
    endtask

    task automatic midReset(input string tag);
        reset_i = 1'b1;
        #1;
        checkOutput(tag, {busy_o, tick_o, clk_o}, 6'b0);
        exp0.delete();
        exp1.delete();
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset_i  = 1'b1;
        en_i     = '0;
        period_i = '0;
        high_i   = '0;
        #12;
        checkOutput("reset_state", {busy_o, tick_o, clk_o}, 6'b0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        repeat (10) applyStimulus("p4h2", 2'b01, 16'd4, 16'd2, 16'd0, 16'd0);
        repeat (1)  applyStimulus("p4h2_c1", 2'b01, 16'd4, 16'd2, 16'd0, 16'd0);
        repeat (10) applyStimulus("to_p3h1", 2'b01, 16'd3, 16'd1, 16'd0, 16'd0);
        repeat (2)  applyStimulus("drain", 2'b00, 16'd3, 16'd1, 16'd0, 16'd0);
        repeat (3)  applyStimulus("idle", 2'b00, 16'd6, 16'd3, 16'd0, 16'd0);

        applyStimulus("p6h3_start", 2'b01, 16'd6, 16'd3, 16'd0, 16'd0);
        applyStimulus("p6h3_c0", 2'b01, 16'd6, 16'd3, 16'd0, 16'd0);
        repeat (7)  applyStimulus("p6h3_drop", 2'b00, 16'd6, 16'd3, 16'd0, 16'd0);
        repeat (8)  applyStimulus("reenable", 2'b01, 16'd6, 16'd3, 16'd0, 16'd0);
        repeat (7)  applyStimulus("stop", 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);

        repeat (5)  applyStimulus("p0", 2'b11, 16'd0, 16'd3, 16'd0, 16'd0);
        repeat (5)  applyStimulus("p1", 2'b11, 16'd1, 16'd1, 16'd1, 16'd5);
        repeat (12) applyStimulus("p5h7", 2'b01, 16'd5, 16'd7, 16'd1, 16'd0);
        repeat (7)  applyStimulus("p5h7_stop", 2'b00, 16'd5, 16'd7, 16'd0, 16'd0);
        repeat (12) applyStimulus("p5h0", 2'b01, 16'd5, 16'd0, 16'd0, 16'd0);
        repeat (7)  applyStimulus("p5h0_stop", 2'b00, 16'd5, 16'd0, 16'd0, 16'd0);

        repeat (6)  applyStimulus("p8h4", 2'b01, 16'd8, 16'd4, 16'd0, 16'd0);
        midReset("async_reset");
        repeat (10) applyStimulus("after_reset", 2'b01, 16'd8, 16'd4, 16'd0, 16'd0);
        repeat (9)  applyStimulus("p8_stop", 2'b00, 16'd8, 16'd4, 16'd0, 16'd0);

        for (int i = 0; i < 60; i++) begin
            logic en1;
            en1 = ((i / 9) % 2) == 0;
            applyStimulus("dual", {en1, 1'b1}, 16'd2, 16'd1, 16'd7, 16'd3);
        end

        for (int i = 0; i < 600; i++) begin
            logic [1:0]  en;
            logic [15:0] p0;
            logic [15:0] h0;
            logic [15:0] p1;
            logic [15:0] h1;
            en = ($urandom_range(0, 9) < 8) ? 2'b11 : 2'($urandom_range(0, 3));
            p0 = 16'($urandom_range(0, 9));
            h0 = 16'($urandom_range(0, 11));
            p1 = 16'($urandom_range(0, 9));
            h1 = 16'($urandom_range(0, 11));
            if ($urandom_range(0, 99) == 0) midReset("rand_reset");
            applyStimulus("random", en, p0, h0, p1, h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
